rf_scoreboard: RTL and testbench

Parametrised register file for the lab CPU core. It has three combinational read ports (ra1/ra2 for operands, ra0 for the debug/PDU view) and one synchronous write port.
- Adds a per-register busy scoreboard. The decode stage uses it to detect RAW hazards against in-flight producers.
- The stack pointer is a real register loaded with SP_INIT at reset, not a hardwired constant.
- It sits between decode (issue and read side) and writeback (write side).

---
 rtl/rf_scoreboard.sv | 66 ++++++
 tb/tb_rf_scoreboard.sv | 109 ++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with RAW busy scoreboard; define RF_BYPASS_EN for write-first read bypass
module rf_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int SP_IDX = 2,
    parameter logic [DW-1:0] SP_INIT = 'h2ffc
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    output logic          busy1,
    output logic          busy2,
    output logic          hazard,
    output logic [AW:0]   busy_cnt
);
    localparam int N = 2**AW;
    logic [DW-1:0] rf [N];
    logic [N-1:0] busy, busy_nxt;
    logic wr, iss, set_new, clr_old;
    logic byp0, byp1, byp2;
    assign wr  = we && wa != '0;
    assign iss = issue_en && issue_rd != '0;
    // a same-index issue supersedes the completing producer, so no decrement
    assign set_new = iss && !busy[issue_rd];
    assign clr_old = wr && busy[wa] && !(iss && issue_rd == wa);
    always_comb begin
        busy_nxt = busy;
        if (wr) busy_nxt[wa] = 1'b0;
        if (iss) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) rf[i] <= i == SP_IDX ? SP_INIT : '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr) rf[wa] <= wd;
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + (AW+1)'(set_new) - (AW+1)'(clr_old);
        end
    end
`ifdef RF_BYPASS_EN
    assign byp0 = wr && ra0 == wa;
    assign byp1 = wr && ra1 == wa;
    assign byp2 = wr && ra2 == wa;
`else
    assign {byp0, byp1, byp2} = 3'b000;
`endif
    assign rd0    = ra0 == '0 ? '0 : byp0 ? wd : rf[ra0];
    assign rd1    = ra1 == '0 ? '0 : byp1 ? wd : rf[ra1];
    assign rd2    = ra2 == '0 ? '0 : byp2 ? wd : rf[ra2];
    assign busy1  = busy[ra1] && !byp1;
    assign busy2  = busy[ra2] && !byp2;
    assign hazard = busy1 || busy2;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed vector table plus fill/drain sequence for rf_scoreboard
module tb_rf_scoreboard;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk, rst, we, issue_en, busy1, busy2, hazard;
    logic [4:0] ra0, ra1, ra2, wa, issue_rd;
    logic [31:0] rd0, rd1, rd2, wd;
    logic [5:0] busy_cnt;
    int checks = 0, fails = 0;
    typedef struct {
        logic rst, we, ie, chk;
        logic [4:0] wa, ir, ra0, ra1, ra2;
        logic [31:0] wd, rd0, rd1, rd2;
        logic b1, b2, hz;
        logic [5:0] cnt;
    } vec_t;
    vec_t vq[$];
    rf_scoreboard dut (
        .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2), .we(we), .wa(wa), .wd(wd),
        .issue_en(issue_en), .issue_rd(issue_rd), .busy1(busy1),
        .busy2(busy2), .hazard(hazard), .busy_cnt(busy_cnt)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic add(input logic r, w, input logic [4:0] a, input logic [31:0] d,
                       input logic ie, input logic [4:0] ir, a0, a1, a2, input logic c,
                       input logic [31:0] e0, e1, e2, input logic b1, b2, hz,
                       input logic [5:0] n);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ie = ie; v.ir = ir;
        v.ra0 = a0; v.ra1 = a1; v.ra2 = a2; v.chk = c;
        v.rd0 = e0; v.rd1 = e1; v.rd2 = e2; v.b1 = b1; v.b2 = b2; v.hz = hz; v.cnt = n;
        vq.push_back(v);
    endtask
    task automatic drive(input logic r, w, input logic [4:0] a, input logic [31:0] d,
                         input logic ie, input logic [4:0] ir, a0, a1, a2);
        @(negedge clk);
        rst = r; we = w; wa = a; wd = d; issue_en = ie; issue_rd = ir;
        ra0 = a0; ra1 = a1; ra2 = a2;
        #1;
    endtask
    task automatic cmp(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        logic [104:0] got, exp;
        //  rst we wa wd        ie ir  ra0 ra1 ra2 chk rd0      rd1      rd2      b1 b2 hz cnt
        add(1, 1, 3, 'hff,      1, 4,  0,  0,  0,  0,  0,       0,       0,       0, 0, 0, 0);
        add(1, 1, 3, 'hff,      1, 4,  5,  0,  2,  1,  0,       0,       'h2ffc,  0, 0, 0, 0);
        add(0, 1, 0, 'hdead,    0, 0,  0,  3,  4,  1,  0,       0,       0,       0, 0, 0, 0);
        add(0, 1, 2, 'h1234,    0, 0,  0,  0,  3,  1,  0,       0,       0,       0, 0, 0, 0);
        add(0, 0, 0, 0,         1, 7,  0,  0,  2,  1,  0,       0,       'h1234,  0, 0, 0, 0);
        add(0, 0, 0, 0,         0, 0,  0,  7,  0,  1,  0,       0,       0,       1, 0, 1, 1);
        add(0, 1, 7, 9,         0, 0,  1,  0,  0,  1,  0,       0,       0,       0, 0, 0, 1);
        add(0, 0, 0, 0,         1, 5,  0,  7,  0,  1,  0,       9,       0,       0, 0, 0, 0);
        add(0, 1, 5, 'h55,      1, 5,  0,  6,  0,  1,  0,       0,       0,       0, 0, 0, 1);
        add(0, 0, 0, 0,         0, 0,  0,  5,  6,  1,  0,       'h55,    0,       1, 0, 1, 1);
        add(0, 1, 5, 'h66,      1, 6,  0,  0,  0,  1,  0,       0,       0,       0, 0, 0, 1);
        add(0, 1, 9, 'h99,      1, 3,  0,  5,  6,  1,  0,       'h66,    0,       0, 1, 1, 1);
        add(0, 1, 3, 'h55,      1, 4,  0,  9,  6,  1,  0,       'h99,    0,       0, 1, 1, 2);
        add(0, 0, 0, 0,         1, 3,  0,  3,  4,  1,  0,       'h55,    0,       0, 1, 1, 2);
        add(0, 0, 0, 0,         1, 9,  0,  3,  0,  1,  0,       'h55,    0,       1, 0, 1, 3);
        add(1, 1, 3, 'h77,      1, 10, 0,  9,  4,  1,  0,       'h99,    0,       1, 1, 1, 4);
        add(0, 0, 0, 0,         1, 8,  2,  3,  9,  1,  'h2ffc,  0,       0,       0, 0, 0, 0);
        add(0, 0, 0, 0,         1, 8,  0,  8,  0,  1,  0,       0,       0,       1, 0, 1, 1);
        add(0, 0, 0, 0,         1, 0,  0,  0,  0,  1,  0,       0,       0,       0, 0, 0, 1);
        add(0, 1, 8, 'habcd,    0, 0,  0,  8,  0,  1,  0,       BYP ? 'habcd : 0, 0, !BYP, 0, !BYP, 1);
        add(0, 0, 0, 0,         0, 0,  0,  8,  0,  1,  0,       'habcd,  0,       0, 0, 0, 0);
        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].we, vq[k].wa, vq[k].wd, vq[k].ie, vq[k].ir,
                  vq[k].ra0, vq[k].ra1, vq[k].ra2);
            if (vq[k].chk) begin
                got = {rd0, rd1, rd2, busy1, busy2, hazard, busy_cnt};
                exp = {vq[k].rd0, vq[k].rd1, vq[k].rd2, vq[k].b1, vq[k].b2, vq[k].hz, vq[k].cnt};
                checks++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL vec%0d {rd0,rd1,rd2,b1,b2,hz,cnt}: got %h expected %h", k, got, exp);
                end
            end
        end
        for (int i = 1; i < 32; i++) drive(0, 0, 0, 0, 1, 5'(i), 0, 31, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 31, 1);
        cmp("fill_cnt", 32'(busy_cnt), 31);
        cmp("fill_hazard", {29'd0, busy1, busy2, hazard}, 7);
        for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), 32'(i) * 3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 31, 1);
        cmp("drain_cnt", 32'(busy_cnt), 0);
        cmp("drain_rd1", rd1, 93);
        cmp("drain_rd0", rd0, 12);
        cmp("drain_hazard", {31'd0, hazard}, 0);
        drive(0, 1, 1, 5, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cmp("no_underflow_cnt", 32'(busy_cnt), 0);
        cmp("rewrite_rd1", rd1, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
